// File: rtl/scaler_pkg.sv
// rtl/scaler_pkg.sv - shared geometry, shift-width helper, lane result type and lane pack/unpack helpers
package scaler_pkg;

  // Lane geometry shared by the struct and the pack/unpack helpers below.
  localparam int SCALER_WIDTH = 16;
  localparam int SCALER_LANES = 4;

  // Shift-amount width: enough to express 0..WIDTH, plus one bit of headroom.
  function automatic int shw_of(input int width);
    return $clog2(width) + 1;
  endfunction

  typedef struct packed {
    logic signed [SCALER_WIDTH-1:0] val;
    logic                           floor_ev;
  } lane_res_t;

  typedef logic [SCALER_LANES*SCALER_WIDTH-1:0] lane_bus_t;

  function automatic logic signed [SCALER_WIDTH-1:0] lane_get(input lane_bus_t bus, input int idx);
    return bus[idx*SCALER_WIDTH +: SCALER_WIDTH];
  endfunction

  function automatic lane_bus_t lane_put(input lane_bus_t bus, input int idx,
                                         input logic [SCALER_WIDTH-1:0] v);
    lane_bus_t b;
    b = bus;
    b[idx*SCALER_WIDTH +: SCALER_WIDTH] = v;
    return b;
  endfunction

endpackage

// File: rtl/scaler_lane_fix.sv
// rtl/scaler_lane_fix.sv - combinational per-lane magnitude shift with floor-to-one and optional rounding
// Ports: sign, mag (|x| as unsigned), shamt in; val (re-signed result), floor_ev (forced to +/-1) out.
// Build macro SCALER_ROUND_EN: round half away from zero for 1 <= shamt < WIDTH-1.
module scaler_lane_fix #(
  parameter int WIDTH = 16,
  parameter int SHW   = 5
) (
  input  logic             sign,
  input  logic [WIDTH-1:0] mag,
  input  logic [SHW-1:0]   shamt,
  output logic [WIDTH-1:0] val,
  output logic             floor_ev
);

  // One extra bit so that the rounding add on mag = 2^(WIDTH-1) cannot wrap.
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] q;

  always_comb begin
    sum = {1'b0, mag};
`ifdef SCALER_ROUND_EN
    if (shamt != '0 && int'(shamt) < WIDTH - 1) begin
      sum = sum + ({{WIDTH{1'b0}}, 1'b1} << (shamt - SHW'(1)));
    end
`endif
    shifted = sum >> shamt;

    q        = '0;
    floor_ev = 1'b0;
    if (mag == '0) begin
      q = '0;
    end else if (shifted == '0) begin
      q        = {{(WIDTH-1){1'b0}}, 1'b1};
      floor_ev = 1'b1;
    end else if (int'(shamt) >= WIDTH - 1) begin
      q = {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      q = shifted[WIDTH-1:0];
    end

    // q never exceeds 2^(WIDTH-1), and only reaches it for a negative input,
    // so the negation always lands in range.
    val = sign ? (~q + 1'b1) : q;
  end

endmodule

// File: rtl/scaler_div_pipe.sv
// rtl/scaler_div_pipe.sv - two-stage multi-lane signed power-of-two down-scaler with floor-event counter
// Ports: clk; rst_n (async, active-low); in_valid/in_ready/in_data/in_shamt input stream;
// out_valid/out_ready/out_data output stream; floor_cnt saturating floor count; cnt_clr sync clear.
// Build macro SCALER_ROUND_EN selects round-half-away-from-zero in the lanes (same latency).
// WIDTH and LANES must match the lane geometry of scaler_pkg.
module scaler_div_pipe
  import scaler_pkg::*;
#(
  parameter int WIDTH = SCALER_WIDTH,
  parameter int LANES = SCALER_LANES,
  parameter int SHW   = shw_of(WIDTH),
  parameter int CNTW  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic [SHW-1:0]         in_shamt,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [CNTW-1:0]        floor_cnt,
  input  logic                   cnt_clr
);

  logic             s1_valid;
  logic             s1_sign [LANES];
  logic [WIDTH-1:0] s1_mag  [LANES];
  logic [SHW-1:0]   s1_shamt;

  logic             s2_valid;
  lane_res_t        s2_res  [LANES];

  logic             in_sign [LANES];
  logic [WIDTH-1:0] in_mag  [LANES];
  logic [WIDTH-1:0] lane_val [LANES];
  logic             lane_fl  [LANES];

  logic             s1_load;
  logic             s2_load;
  lane_bus_t        out_bus;
  logic [CNTW:0]    inc;
  logic [CNTW:0]    cnt_sum;

  // S2 advances into a bubble without waiting for downstream.
  assign s2_load   = !s2_valid || out_ready;
  assign s1_load   = !s1_valid || s2_load;
  assign in_ready  = s1_load;
  assign out_valid = s2_valid;

  always_comb begin : p_split
    logic signed [WIDTH-1:0] x;
    x = '0;
    for (int i = 0; i < LANES; i++) begin
      x          = lane_get(in_data, i);
      in_sign[i] = x[WIDTH-1];
      // -(-2^(WIDTH-1)) wraps to the same bit pattern, which read unsigned is 2^(WIDTH-1).
      in_mag[i]  = x[WIDTH-1] ? (~x + 1'b1) : x;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_shamt <= '0;
      for (int i = 0; i < LANES; i++) begin
        s1_sign[i] <= 1'b0;
        s1_mag[i]  <= '0;
      end
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_shamt <= in_shamt;
        for (int i = 0; i < LANES; i++) begin
          s1_sign[i] <= in_sign[i];
          s1_mag[i]  <= in_mag[i];
        end
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    scaler_lane_fix #(
      .WIDTH (WIDTH),
      .SHW   (SHW)
    ) u_lane (
      .sign     (s1_sign[g]),
      .mag      (s1_mag[g]),
      .shamt    (s1_shamt),
      .val      (lane_val[g]),
      .floor_ev (lane_fl[g])
    );
  end

  // Result payload is only rewritten when a real transaction moves in, so a
  // stalled output stays put and a bubble keeps the previous value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        s2_res[i] <= '0;
      end
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        for (int i = 0; i < LANES; i++) begin
          s2_res[i].val      <= lane_val[i];
          s2_res[i].floor_ev <= lane_fl[i];
        end
      end
    end
  end

  always_comb begin
    out_bus = '0;
    for (int i = 0; i < LANES; i++) begin
      out_bus = lane_put(out_bus, i, s2_res[i].val);
    end
  end
  assign out_data = out_bus;

  always_comb begin
    inc = '0;
    for (int i = 0; i < LANES; i++) begin
      inc = inc + {{CNTW{1'b0}}, s2_res[i].floor_ev};
    end
    cnt_sum = {1'b0, floor_cnt} + inc;
  end

  // Clear has priority over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      floor_cnt <= '0;
    end else if (cnt_clr) begin
      floor_cnt <= '0;
    end else if (s2_valid && out_ready) begin
      floor_cnt <= cnt_sum[CNTW] ? '1 : cnt_sum[CNTW-1:0];
    end
  end

endmodule

// File: tb/tb_scaler_div_pipe.sv
// tb/tb_scaler_div_pipe.sv - randomized self-checking bench for scaler_div_pipe against a transaction-level model
module tb_scaler_div_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = '0;
  logic [4:0]  in_shamt = '0;
  logic        out_ready;
  logic        cnt_clr;
  logic        in_ready, out_valid;
  logic [63:0] out_data;
  logic [15:0] floor_cnt;
  logic        in_ready4, out_valid4;
  logic [63:0] out_data4;
  logic [3:0]  floor_cnt4;

  always #5 clk = ~clk;

  scaler_div_pipe #(.WIDTH(16), .LANES(4), .SHW(5), .CNTW(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_shamt(in_shamt), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .floor_cnt(floor_cnt), .cnt_clr(cnt_clr));

  scaler_div_pipe #(.WIDTH(16), .LANES(4), .SHW(5), .CNTW(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data), .in_shamt(in_shamt), .out_valid(out_valid4), .out_ready(out_ready),
    .out_data(out_data4), .floor_cnt(floor_cnt4), .cnt_clr(cnt_clr));

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference arithmetic straight from the division rules.
  function automatic void lane_ref(input int x, input int sh, output int r, output int fl);
    longint mag, d, q;
    fl = 0;
    r  = 0;
    if (x == 0) return;
    mag = (x < 0) ? -longint'(x) : longint'(x);
    d   = longint'(1) << sh;
    q   = mag / d;
`ifdef SCALER_ROUND_EN
    if (sh >= 1 && sh < 15) q = (mag + d / 2) / d;
`endif
    if (q == 0) begin
      q  = 1;
      fl = 1;
    end
    if (sh >= 15) q = 1;
    r = (x < 0) ? -int'(q) : int'(q);
  endfunction

  function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
    logic [15:0] la, lb, lc, ld;
    la = a[15:0]; lb = b[15:0]; lc = c[15:0]; ld = d[15:0];
    return {ld, lc, lb, la};
  endfunction

  typedef struct {
    logic [63:0] data;
    int          nfl;
    int          acc;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  longint      mcnt = 0;
  longint      mcnt4 = 0;
  logic [63:0] last_out = '0;
  int          or_mode = 0;
  logic        clr_req = 1'b0;
  logic [3:0]  pat = 4'b1001;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    out_ready = 1'b1;
    cnt_clr   = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (or_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = pat[cyc % 4];
        2:       out_ready = ($urandom_range(0, 2) != 0);
        default: out_ready = 1'b0;
      endcase
      cnt_clr = clr_req || (or_mode == 2 && $urandom_range(0, 15) == 0);
    end
  end

  // Monitor: checks the observable state, then applies the transfers the
  // model expects at the coming rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      mcnt  = 0;
      mcnt4 = 0;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_floor_cnt", floor_cnt, 0);
      chk("rst_floor_cnt4", floor_cnt4, 0);
    end else begin
      logic exp_ir, exp_ov;
      exp_t e;
      chk("floor_cnt", floor_cnt, mcnt);
      chk("floor_cnt4", floor_cnt4, mcnt4);
      exp_ir = (q.size() < 2) || out_ready;
      exp_ov = (q.size() > 0) && (cyc - q[0].acc >= 1);
      chk("in_ready", in_ready, exp_ir);
      chk("in_ready4", in_ready4, exp_ir);
      chk("out_valid", out_valid, exp_ov);
      chk("out_valid4", out_valid4, exp_ov);
      if (exp_ov) begin
        chk("out_data", out_data, q[0].data);
        chk("out_data4", out_data4, q[0].data);
      end
      if (cnt_clr) begin
        mcnt  = 0;
        mcnt4 = 0;
      end else if (exp_ov && out_ready) begin
        mcnt  = (mcnt + q[0].nfl > 65535) ? 65535 : mcnt + q[0].nfl;
        mcnt4 = (mcnt4 + q[0].nfl > 15) ? 15 : mcnt4 + q[0].nfl;
      end
      if (exp_ov && out_ready) begin
        last_out = out_data;
        void'(q.pop_front());
      end
      if (in_valid && exp_ir) begin
        e.data = '0;
        e.nfl  = 0;
        for (int i = 0; i < 4; i++) begin
          int r, fl;
          logic signed [15:0] xs;
          xs = in_data[i*16 +: 16];
          lane_ref(int'(xs), int'(in_shamt), r, fl);
          e.data[i*16 +: 16] = r[15:0];
          e.nfl += fl;
        end
        e.acc = cyc + 1;
        q.push_back(e);
      end
    end
  end

  task automatic send(input logic [63:0] d, input logic [4:0] sh);
    bit acc;
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = sh;
    acc = 0;
    n   = 0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  // Waits until the model pipeline is empty, then one more edge so the
  // counter has absorbed the last completion; ends at a falling edge.
  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) chk("drain_timeout", 0, 1);
    @(negedge clk);
  endtask

  function automatic logic [63:0] rnd_data();
    logic [63:0] d;
    for (int i = 0; i < 4; i++) begin
      case ($urandom_range(0, 5))
        0:       d[i*16 +: 16] = 16'h8000;
        1:       d[i*16 +: 16] = 16'h7fff;
        2:       d[i*16 +: 16] = 16'h0000;
        3:       d[i*16 +: 16] = 16'($urandom_range(0, 15)) - 16'd8;
        default: d[i*16 +: 16] = 16'($urandom);
      endcase
    end
    return d;
  endfunction

  initial begin
    logic [63:0] exp_basic;
    int          exp_basic_cnt;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_out_data", out_data, 0);

    // Basic values.
`ifdef SCALER_ROUND_EN
    exp_basic     = pack4(13, -13, 1, -1);
    exp_basic_cnt = 0;
`else
    exp_basic     = pack4(12, -12, 1, -1);
    exp_basic_cnt = 2;
`endif
    @(posedge clk); #1;
    send(pack4(100, -100, 7, -7), 5'd3);
    drain();
    chk("basic_data", last_out, exp_basic);
    chk("basic_cnt", floor_cnt, exp_basic_cnt);

    // Extremes: identity at shamt 0, saturation to +/-1 at shamt 15.
    @(posedge clk); #1;
    send(pack4(-32768, 32767, 0, 1), 5'd0);
    drain();
    chk("ext_sh0", last_out, pack4(-32768, 32767, 0, 1));
    @(posedge clk); #1;
    send(pack4(-32768, 32767, 0, 1), 5'd15);
    drain();
    chk("ext_sh15", last_out, pack4(-1, 1, 0, 1));

    // Backpressure with out_ready cycling 1,0,0,1.
    or_mode = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) send(rnd_data(), 5'($urandom_range(0, 20)));
    drain();
    or_mode = 0;

    // Random traffic with random backpressure, gaps and clears.
    or_mode = 2;
    @(posedge clk); #1;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      send(rnd_data(), 5'($urandom_range(0, 31)));
    end
    drain();
    or_mode = 0;

    // Counter saturation on the 4-bit instance, then clear against a completion.
    @(negedge clk) clr_req = 1'b1;
    @(negedge clk) clr_req = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) send(pack4(1, 2, 3, -4), 5'd20);
    drain();
    chk("sat_cnt4", floor_cnt4, 15);
    chk("sat_cnt16", floor_cnt, 20);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = pack4(5, -5, 9, -9);
    in_shamt = 5'd6;
    repeat (3) @(negedge clk);
    clr_req = 1'b1;
    @(negedge clk) clr_req = 1'b0;
    @(negedge clk);
    chk("clr_cnt4", floor_cnt4, 0);
    chk("clr_cnt16", floor_cnt, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    // Reset with both stages full.
    or_mode = 3;
    @(posedge clk); #1;
    send(rnd_data(), 5'd2);
    send(rnd_data(), 5'd4);
    @(negedge clk);
    chk("full_in_ready", in_ready, 0);
    chk("full_out_valid", out_valid, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_floor_cnt", floor_cnt, 0);
    chk("mid_rst_out_data", out_data, 0);
    @(posedge clk); #1;
    rst_n   = 1'b1;
    or_mode = 0;
    @(posedge clk); #1;
    send(pack4(64, -64, 3, 0), 5'd2);
    drain();
    chk("post_rst_data", last_out, pack4(16, -16, 1, 0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
